// File: rtl/p_hit_pkg.sv
// ---------------------------------------------------------------------------
// p_hit_pkg
// Shared types and constants for the hit-point stage (p_hit_2_module) and its
// sequential divider (q_div_seq).
//   Q_BITS_DEFAULT    : fractional bits of every fixed-point value
//   DIV_ITERS_DEFAULT : quotient bits the divider produces (one per cycle)
//   fixed_t / vec3_t  : signed Q-format scalar and 3-vector ([2:0] = z,y,x)
//   p_hit_state_t     : stage FSM states
//   FIX_MAX / FIX_MIN : saturation limits (FIX_MIN is -FIX_MAX, symmetric)
// ---------------------------------------------------------------------------
package p_hit_pkg;

  localparam int Q_BITS_DEFAULT    = 10;
  localparam int DIV_ITERS_DEFAULT = 32 + Q_BITS_DEFAULT;

  typedef logic signed [31:0] fixed_t;
  typedef fixed_t [2:0]       vec3_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    MUL   = 2'd2,
    WRITE = 2'd3
  } p_hit_state_t;

  // A saturated negative t is the negation of FIX_MAX, not the most negative
  // 32-bit value, so magnitude and sign stay independent.
  localparam fixed_t FIX_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIX_MIN = 32'sh8000_0001;

endpackage

// File: rtl/p_hit_2_module_div.sv
// ---------------------------------------------------------------------------
// q_div_seq
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clock, reset     : clock, asynchronous active-low reset
//   start            : load dividend/divisor and begin ITERS iterations
//   dividend[ITERS]  : dividend magnitude (already scaled by the caller)
//   divisor[32]      : divisor magnitude
//   busy             : iterations outstanding
//   done             : final iteration completes at the end of this cycle;
//                      quotient is valid from the next cycle until next start
//   quotient[32]     : quotient magnitude saturated to FIX_MAX
// Parameters: ITERS (iteration count), ROUND (last quotient bit is a guard
// bit used to round half-up before saturation).
// A zero divisor is not special-cased: the loop still runs ITERS cycles and
// yields all-ones, which saturates; the caller decides what to do with it.
// ---------------------------------------------------------------------------
module q_div_seq
  import p_hit_pkg::*;
#(
  parameter int ITERS = DIV_ITERS_DEFAULT,
  parameter bit ROUND = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ITERS-1:0]  dividend,
  input  logic [31:0]       divisor,
  output logic              busy,
  output logic              done,
  output logic [31:0]       quotient
);

  localparam int CNT_W = $clog2(ITERS + 1);

  logic [31:0]      rem_q, rem_d;
  logic [ITERS-1:0] quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]      trial;
  logic             fits;
  logic [ITERS-1:0] mag_full;

  // quo_q doubles as the dividend shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    trial = {rem_q, quo_q[ITERS-1]};
    fits  = (trial >= {1'b0, dvs_q});
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CNT_W'(ITERS);
    end else if (cnt_q != '0) begin
      rem_d = fits ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
      quo_d = {quo_q[ITERS-2:0], fits};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    if (ROUND) begin
      mag_full = (quo_q >> 1) + {{(ITERS-1){1'b0}}, quo_q[0]};
    end else begin
      mag_full = quo_q;
    end
    if (|mag_full[ITERS-1:31]) begin
      quotient = FIX_MAX;
    end else begin
      quotient = mag_full[31:0];
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/p_hit_2_module.sv
// ---------------------------------------------------------------------------
// p_hit_2_module
// Second stage of the ray/triangle hit-point pipeline. Pops one dot-product
// record, computes t = (n.v0 - n.origin) / n.dir and p_hit = origin + t*dir,
// and writes t, p_hit and a forward-hit flag to the downstream FIFO.
// Ports:
//   clock, reset            : clock, asynchronous active-low reset
//   n_dot_v0/origin/dir     : stage-1 dot products (FWFT FIFO data)
//   origin, dir             : ray origin/direction, [2:0] = z,y,x
//   in_empty / in_rd_en     : input FIFO status / pop
//   p_hit, t, hit           : registered results
//   out_wr_en / out_full    : output FIFO write strobe / status
// Optional feature: define P_HIT_ROUND_EN for round-half-up in both the
// divider (one extra guard iteration) and the multiply; latency grows by 1.
// ---------------------------------------------------------------------------
module p_hit_2_module
  import p_hit_pkg::*;
#(
  parameter int Q_BITS    = Q_BITS_DEFAULT,
  parameter int DIV_ITERS = 32 + Q_BITS
) (
  input  logic         clock,
  input  logic         reset,
  input  fixed_t       n_dot_v0,
  input  fixed_t       n_dot_origin,
  input  fixed_t       n_dot_dir,
  input  vec3_t        origin,
  input  vec3_t        dir,
  input  logic         in_empty,
  output logic         in_rd_en,
  output vec3_t        p_hit,
  output fixed_t       t,
  output logic         hit,
  output logic         out_wr_en,
  input  logic         out_full
);

`ifdef P_HIT_ROUND_EN
  localparam int ITERS    = DIV_ITERS + 1;
  localparam bit ROUND_EN = 1'b1;
`else
  localparam int ITERS    = DIV_ITERS;
  localparam bit ROUND_EN = 1'b0;
`endif

  p_hit_state_t state_q, state_d;
  logic         neg_q, neg_d;
  logic         zden_q, zden_d;
  vec3_t        origin_q, origin_d;
  vec3_t        dir_q, dir_d;
  fixed_t       t_q, t_d;
  vec3_t        p_hit_q, p_hit_d;
  logic         hit_q, hit_d;

  logic signed [32:0] num;
  logic [31:0]        abs_num;
  logic [31:0]        abs_den;
  logic [ITERS-1:0]   dividend;
  logic               div_busy, div_done;
  logic [31:0]        div_mag;
  fixed_t             t_calc;
  logic signed [63:0] t_wide, dir_wide, prod;

  // 33-bit difference cannot wrap; its magnitude always fits in 32 bits.
  assign num      = {n_dot_v0[31], n_dot_v0} - {n_dot_origin[31], n_dot_origin};
  assign abs_num  = num[32] ? 32'(-num) : num[31:0];
  assign abs_den  = n_dot_dir[31] ? (-n_dot_dir) : n_dot_dir;
  assign dividend = {abs_num, {(ITERS-32){1'b0}}};

  // Reset gates the pop so nothing leaves the FIFO while the stage is held.
  assign in_rd_en  = reset && (state_q == IDLE) && !in_empty;
  assign out_wr_en = (state_q == WRITE) && !out_full;

  q_div_seq #(
    .ITERS (ITERS),
    .ROUND (ROUND_EN)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (in_rd_en),
    .dividend (dividend),
    .divisor  (abs_den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_mag)
  );

  assign t_calc = neg_q ? fixed_t'(-div_mag) : fixed_t'(div_mag);

  always_comb begin
    state_d  = state_q;
    neg_d    = neg_q;
    zden_d   = zden_q;
    origin_d = origin_q;
    dir_d    = dir_q;
    t_d      = t_q;
    p_hit_d  = p_hit_q;
    hit_d    = hit_q;
    t_wide   = t_calc;
    dir_wide = '0;
    prod     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_rd_en) begin
          neg_d    = num[32] ^ n_dot_dir[31];
          zden_d   = (n_dot_dir == '0);
          origin_d = origin;
          dir_d    = dir;
          state_d  = DIV;
        end
      end
      DIV: begin
        if (div_done || !div_busy) begin
          state_d = MUL;
        end
      end
      MUL: begin
        if (zden_q) begin
          t_d     = '0;
          p_hit_d = origin_q;
          hit_d   = 1'b0;
        end else begin
          t_d   = t_calc;
          hit_d = (t_calc > 0);
          for (int i = 0; i < 3; i++) begin
            dir_wide = $signed(dir_q[i]);
            prod     = t_wide * dir_wide;
            if (ROUND_EN) begin
              prod = prod + (64'sd1 <<< (Q_BITS - 1));
            end
            p_hit_d[i] = origin_q[i] + 32'(prod >>> Q_BITS);
          end
        end
        state_d = WRITE;
      end
      WRITE: begin
        if (out_wr_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      neg_q    <= 1'b0;
      zden_q   <= 1'b0;
      origin_q <= '0;
      dir_q    <= '0;
      t_q      <= '0;
      p_hit_q  <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      neg_q    <= neg_d;
      zden_q   <= zden_d;
      origin_q <= origin_d;
      dir_q    <= dir_d;
      t_q      <= t_d;
      p_hit_q  <= p_hit_d;
      hit_q    <= hit_d;
    end
  end

  assign t     = t_q;
  assign p_hit = p_hit_q;
  assign hit   = hit_q;

endmodule

// File: doc/p_hit_2_module.md
Name: p_hit_2_module

Overview:
- Second stage of the ray/triangle hit-point pipeline; reader side of the stage-1 dot-product FIFO.
- Pops one record per ray: n·v0, n·origin, n·dir, origin, dir. All values are signed 32-bit fixed point with Q_BITS fractional bits.
- Computes t = (n·v0 − n·origin) / (n·dir) with a sequential restoring divider, then p_hit = origin + t·dir.
- Writes t, p_hit and a hit flag into the downstream FIFO.

Parameters:
Q_BITS, 10, number of fractional bits of every fixed-point operand and result
DIV_ITERS, 32+Q_BITS, quotient bits produced by the divider (one per cycle)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
n_dot_v0  in  32 signed  stage-1 dot n·v0 (FIFO dout, first-word-fall-through)
n_dot_origin  in  32 signed  stage-1 dot n·origin
n_dot_dir  in  32 signed  n·dir (denominator)
origin  in  3x32 signed  ray origin [2:0] = z,y,x
dir  in  3x32 signed  ray direction
in_empty  in  1  input FIFO empty
in_rd_en  out  1  input FIFO pop
p_hit  out  3x32 signed  hit point
t  out  32 signed  ray parameter
hit  out  1  1 = valid forward intersection
out_wr_en  out  1  output FIFO write strobe
out_full  in  1  output FIFO full

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Reset low forces state IDLE and clears all registers: p_hit=0, t=0, hit=0, in_rd_en=0, out_wr_en=0.
- Reset mid-operation: an already-popped record is dropped and no partial write occurs.
- FSM states: IDLE → DIV → MUL → WRITE → IDLE.
- IDLE: in_rd_en = !in_empty (combinational). When in_rd_en=1, capture all inputs in the same edge:
  - num = n_dot_v0 − n_dot_origin, 33-bit signed, no wrap.
  - den = n_dot_dir.
  - neg = sign(num) XOR sign(den).
  - zden = (den==0).
  - Load divider: dividend = |num| << Q_BITS; divisor = |den|.
  - Next state DIV.
- DIV: restoring division, one quotient bit per cycle, exactly DIV_ITERS cycles. Runs for the full count even when zden=1, so latency stays deterministic.
  - Magnitude quotient > 2^31−1 saturates to 0x7FFFFFFF.
  - If neg=1, t = −magnitude; a saturated negative result is 0x80000001.
- MUL: one cycle.
  - prod[i] = (64-bit t·dir[i]) >>> Q_BITS (arithmetic shift, truncate toward −inf).
  - p_hit[i] = origin[i] + prod[i][31:0], 32-bit wrap.
  - hit = !zden && (t > 0).
  - If zden=1: t=0, p_hit=origin, hit=0.
- WRITE: out_wr_en = !out_full (combinational). Outputs are registered and stable for the whole state. When out_wr_en=1, next state is IDLE; otherwise hold in WRITE indefinitely.
- Pops only in IDLE; at most one record is in flight. in_rd_en is never asserted outside IDLE.
- Latency: pop at cycle k → DIV cycles k+1..k+DIV_ITERS → MUL at k+DIV_ITERS+1 → out_wr_en at k+DIV_ITERS+2 (k+44 for Q_BITS=10) if !out_full.
- Throughput: IDLE at k+DIV_ITERS+3, so one record per DIV_ITERS+3 cycles with no back-pressure.
- Simultaneous events: in_empty falling during DIV/MUL/WRITE is ignored until IDLE. out_full rising while in WRITE stalls the write; the data is preserved.

Optional Feature:
- Macro: P_HIT_ROUND_EN.
- Defined: MUL adds 1<<(Q_BITS−1) to the 64-bit product before the >>> Q_BITS shift (round half up). The divider also produces one extra guard bit and rounds the quotient magnitude half-up before saturation. DIV then takes DIV_ITERS+1 cycles and every downstream latency figure increases by 1.
- Undefined: truncation exactly as above.

Decomposition:
- Package p_hit_pkg holds:
  - Q_BITS default and DIV_ITERS constant.
  - fixed_t typedef (logic signed [31:0]) and vec3_t typedef (fixed_t [2:0]).
  - State enum p_hit_state_t {IDLE, DIV, MUL, WRITE}.
  - FIX_MAX/FIX_MIN saturation constants.
- One sub-module, q_div_seq:
  - Inputs: start, dividend magnitude, divisor magnitude.
  - Outputs: busy, done, 32-bit saturated magnitude.
  - Iteration count parameterised by DIV_ITERS.

Test Plan:
1. Basic hit, Q_BITS=10: n_dot_v0=5120, n_dot_origin=1024, n_dot_dir=1024, origin=(0,0,0), dir=(1024,0,0), pop at cycle k → out_wr_en at k+44 with t=4096, p_hit=(4096,0,0), hit=1.
2. Negative t: n_dot_v0=0, n_dot_origin=2048, n_dot_dir=1024 → t=−2048, hit=0, p_hit=origin−2·dir.
3. Zero denominator: n_dot_dir=0, origin=(100,200,300) → t=0, p_hit=(100,200,300), hit=0, same latency k+44.
4. Saturation: n_dot_v0=0x7FFFFFFF, n_dot_origin=0, n_dot_dir=1 → t=0x7FFFFFFF, hit=1, no X or wrap.
5. Back-pressure: hold out_full=1 for 10 cycles in WRITE → out_wr_en=0 and outputs stable throughout, then one write cycle. in_rd_en stays 0 until IDLE; the next queued record is popped the cycle after the write.
6. Reset mid-DIV: drop reset low at k+20 → all outputs 0 immediately (async). After release, the next record is processed normally and the dropped record is never written.
